// File: rtl/timer_counter.sv
// timer_counter: memory-mapped down-counter with one-shot and auto-reload modes.
//
// Ports:
//   clk   - system clock, all state updates on the rising edge
//   reset - synchronous, active-high reset
//   Addr  - word address [31:2]; only Addr[3:2] is decoded (range select is upstream)
//   WE    - write strobe, already qualified by the upstream address decode
//   Din   - write data
//   Dout  - read data, combinational on Addr[3:2]
//   IRQ   - interrupt request (IM & irq_flag)
//
// Register map on Addr[3:2]:
//   00 CTRL   (rw) bit0 Enable, bits[2:1] Mode, bit3 IM
//   01 PRESET (rw) 32-bit reload value
//   10 COUNT  (ro)
//   11 reserved, reads 0
module timer_counter (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCnt,
        StInt
    } state_e;

    localparam logic [1:0] AddrCtrl   = 2'b00;
    localparam logic [1:0] AddrPreset = 2'b01;
    localparam logic [1:0] AddrCount  = 2'b10;
    localparam logic [1:0] ModeReload = 2'b01;

    state_e      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic        enable;
    logic [1:0]  mode;
    logic        im;
    logic        wr_ctrl;
    logic        wr_preset;

    // Upper address bits are decoded upstream.
    logic unused_addr;
    assign unused_addr = ^Addr[31:4];

    assign enable    = ctrl_q[0];
    assign mode      = ctrl_q[2:1];
    assign im        = ctrl_q[3];
    assign wr_ctrl   = WE && (Addr[3:2] == AddrCtrl);
    assign wr_preset = WE && (Addr[3:2] == AddrPreset);

    always_comb begin
        state_d    = state_q;
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        // Any CPU write to CTRL or PRESET acknowledges a pending interrupt.
        // Placed before the FSM so a simultaneous expiry is not lost.
        if (wr_ctrl || wr_preset) begin
            irq_flag_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (enable) begin
                    state_d = StLoad;
                end
            end
            StLoad: begin
                count_d = preset_q;
                state_d = StCnt;
            end
            StCnt: begin
                if (!enable) begin
                    state_d = StIdle;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    // Covers PRESET of 0 and 1 without wrapping below zero.
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = StInt;
                end
            end
            StInt: begin
                state_d = StIdle;
                if (mode == ModeReload) begin
                    irq_flag_d = 1'b0;
                end else begin
                    ctrl_d[0] = 1'b0;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // CPU writes come last so a CTRL write beats the one-shot Enable clear.
        if (wr_ctrl) begin
            ctrl_d = Din[3:0];
        end
        if (wr_preset) begin
            preset_d = Din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            AddrCtrl:   Dout = {28'd0, ctrl_q};
            AddrPreset: Dout = preset_q;
            AddrCount:  Dout = count_q;
            default:    Dout = 32'd0;
        endcase
    end

    assign IRQ = im & irq_flag_q;

endmodule
